// File: rtl/intc_pkg.sv
// Shared types and constants for the sc_intr_ctrl interrupt controller.
// The optional edge-trigger feature is enabled by defining INTC_EDGE_TRIG_EN.
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_ACK     = 2'd2,
        ST_SERVICE = 2'd3
    } state_e;

    localparam logic [2:0] ADDR_MASK = 3'd0;
    localparam logic [2:0] ADDR_PEND = 3'd1;
    localparam logic [2:0] ADDR_EOI  = 3'd2;
    localparam logic [2:0] ADDR_ID   = 3'd3;
    localparam logic [2:0] ADDR_TRIG = 3'd4;

    // The ID field has to hold NUM_SRC itself, which is the spurious marker.
    function automatic int id_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins; id = NUM_SRC when nothing is set.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = id_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        valid = |req;
        id    = ID_W'(NUM_SRC);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/sc_intr_ctrl.sv
// Prioritised, maskable interrupt controller for the single-cycle MIPS core.
// Define INTC_EDGE_TRIG_EN to add the TRIG register and per-source edge triggering.
module sc_intr_ctrl
    import intc_pkg::*;
#(
    parameter int          NUM_SRC    = 8,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0008,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    output logic               intr,
    input  logic               inta,
    input  logic               wen,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [31:0]        vector,
    output logic               busy
);

    localparam int ID_W = id_width(NUM_SRC);

    state_e             state_q, state_d;
    logic               intr_q, intr_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [31:0]        vector_q, vector_d;

    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] eligible;
    logic               elig_any;
    logic [ID_W-1:0]    enc_id;
    logic               ack_take;
    logic               eoi_wr;

    assign ack_take = (state_q == ST_REQ) && inta;
    assign eoi_wr   = wen && (addr == ADDR_EOI) && (state_q == ST_SERVICE);
    assign eligible = pend & mask_q;

    intc_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .req   (eligible),
        .valid (elig_any),
        .id    (enc_id)
    );

`ifdef INTC_EDGE_TRIG_EN
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] trig_q, trig_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] ack_clr;

    always_comb begin
        trig_d = trig_q;
        if (wen && (addr == ADDR_TRIG)) begin
            trig_d = wdata[NUM_SRC-1:0];
        end
        ack_clr = '0;
        if (ack_take && elig_any) begin
            ack_clr = NUM_SRC'(1) << enc_id;
        end
        // A rising edge in the acknowledge cycle outranks the clear.
        pend_d = ((pend_q & ~ack_clr) | (irq & ~irq_q)) & trig_q;
        pend   = (pend_q & trig_q) | (irq & ~trig_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irq_q  <= '0;
            trig_q <= '0;
            pend_q <= '0;
        end else begin
            irq_q  <= irq;
            trig_q <= trig_d;
            pend_q <= pend_d;
        end
    end
`else
    assign pend = irq;
`endif

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        id_d     = id_q;
        vector_d = vector_q;

        if (wen && (addr == ADDR_MASK)) begin
            mask_d = wdata[NUM_SRC-1:0];
        end

        case (state_q)
            ST_IDLE: begin
                if (elig_any) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (inta) begin
                    state_d = ST_ACK;
                end else if (!elig_any) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK:     state_d = ST_SERVICE;
            ST_SERVICE: begin
                if (eoi_wr) state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase

        // Capture the winner as inta is taken so the vector is valid during ACK.
        if (ack_take) begin
            id_d     = enc_id;
            vector_d = VEC_BASE + 32'(enc_id) * VEC_STRIDE;
        end

        intr_d = (state_d == ST_REQ);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            intr_q   <= 1'b0;
            mask_q   <= '0;
            id_q     <= ID_W'(NUM_SRC);
            vector_q <= '0;
        end else begin
            state_q  <= state_d;
            intr_q   <= intr_d;
            mask_q   <= mask_d;
            id_q     <= id_d;
            vector_q <= vector_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_MASK: rdata = 32'(mask_q);
            ADDR_PEND: rdata = 32'(pend);
            ADDR_ID:   rdata = 32'(id_q);
`ifdef INTC_EDGE_TRIG_EN
            ADDR_TRIG: rdata = 32'(trig_q);
`endif
            default:   rdata = '0;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^wdata;

    assign intr   = intr_q;
    assign vector = vector_q;
    assign busy   = (state_q == ST_SERVICE);

endmodule
